// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mem_arb_pkg : shared state encoding and byte-lane helpers for mem_arbiter
// Revision    : 1.0
// ---------------------------------------------------------------------------
package mem_arb_pkg;

  localparam int BSEL_W = 2;
  localparam int BYTE_W = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ACCESS = 3'd1,
    RMW_RD = 3'd2,
    RMW_WR = 3'd3,
    RESP   = 3'd4
  } state_e;

  function automatic logic [31:0] lane_extract(input logic [31:0]       word,
                                               input logic [BSEL_W-1:0] bsel);
    logic [31:0] res;
    res               = '0;
    res[BYTE_W-1:0]   = word[bsel*BYTE_W +: BYTE_W];
    return res;
  endfunction

  function automatic logic [31:0] lane_merge(input logic [31:0]       word,
                                             input logic [BSEL_W-1:0] bsel,
                                             input logic [BYTE_W-1:0] data);
    logic [31:0] res;
    res                          = word;
    res[bsel*BYTE_W +: BYTE_W]   = data;
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_arbiter_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mem_arbiter_if : requester handshakes plus single-port memory pins
// Revision       : 1.0
// ---------------------------------------------------------------------------
interface mem_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 18,
  parameter int DATA_W  = 32
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ-1:0]        req_write;
  logic [NUM_REQ-1:0]        req_byte;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*2-1:0]      req_bsel;
  logic [NUM_REQ*DATA_W-1:0] req_wdata;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic [NUM_REQ-1:0]        rsp_ready;
  logic [DATA_W-1:0]         rsp_data;
  logic [ADDR_W-1:0]         mem_address;
  logic [DATA_W-1:0]         mem_write_data;
  logic                      mem_read;
  logic                      mem_write;
  logic                      mem_byte_ops;
  logic [DATA_W-1:0]         mem_read_data;
  logic                      busy;

  modport slave (
    input  req_valid, req_write, req_byte, req_addr, req_bsel, req_wdata,
    input  rsp_ready, mem_read_data,
    output req_ready, rsp_valid, rsp_data,
    output mem_address, mem_write_data, mem_read, mem_write, mem_byte_ops, busy
  );

  modport master (
    output req_valid, req_write, req_byte, req_addr, req_bsel, req_wdata,
    output rsp_ready, mem_read_data,
    input  req_ready, rsp_valid, rsp_data,
    input  mem_address, mem_write_data, mem_read, mem_write, mem_byte_ops, busy
  );
endinterface
`default_nettype wire

// File: rtl/mem_arbiter_rr_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rr_arbiter : round-robin grant; fixed lowest-index priority when
//              MEM_ARB_FIXED_PRIO_EN is defined (pointer then removed)
// Revision   : 1.0
// ---------------------------------------------------------------------------
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = 1
) (
`ifndef MEM_ARB_FIXED_PRIO_EN
  input  logic               clk,
  input  logic               rst_n,
`endif
  input  logic               i_en,
  input  logic [NUM_REQ-1:0] i_req,
  output logic [NUM_REQ-1:0] o_gnt,
  output logic [IDX_W-1:0]   o_gnt_idx,
  output logic               o_gnt_vld
);

  logic [NUM_REQ-1:0] w_gnt;
  logic [IDX_W-1:0]   w_idx;
  logic               w_found;

`ifdef MEM_ARB_FIXED_PRIO_EN
  always_comb begin
    w_gnt   = '0;
    w_idx   = '0;
    w_found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!w_found && i_req[k]) begin
        w_found  = 1'b1;
        w_gnt[k] = 1'b1;
        w_idx    = IDX_W'(k);
      end
    end
  end
`else
  logic [IDX_W-1:0] r_ptr;
  int               w_slot;

  // Scan starts at the pointer and wraps, so the last winner goes to the back.
  always_comb begin
    w_gnt   = '0;
    w_idx   = '0;
    w_found = 1'b0;
    w_slot  = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_slot = (int'(r_ptr) + k) % NUM_REQ;
      if (!w_found && i_req[w_slot]) begin
        w_found       = 1'b1;
        w_gnt[w_slot] = 1'b1;
        w_idx         = IDX_W'(w_slot);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (i_en && w_found) begin
      r_ptr <= (int'(w_idx) == NUM_REQ - 1) ? '0 : w_idx + IDX_W'(1);
    end
  end
`endif

  assign o_gnt     = i_en ? w_gnt : '0;
  assign o_gnt_idx = w_idx;
  assign o_gnt_vld = i_en && w_found;

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mem_arbiter : shares one single-ported word memory among NUM_REQ requesters,
//               byte stores as read-modify-write; MEM_ARB_FIXED_PRIO_EN option
// Revision    : 1.0
// ---------------------------------------------------------------------------
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 18,
  parameter int DATA_W  = 32
) (
  input logic          clk,
  input logic          rst_n,
  mem_arbiter_if.slave bus
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  localparam logic [2:0] S_IDLE   = IDLE;
  localparam logic [2:0] S_ACCESS = ACCESS;
  localparam logic [2:0] S_RMW_RD = RMW_RD;
  localparam logic [2:0] S_RMW_WR = RMW_WR;
  localparam logic [2:0] S_RESP   = RESP;

  logic [2:0]        r_state;
  logic [IDX_W-1:0]  r_owner;
  logic              r_write;
  logic              r_byte;
  logic [ADDR_W-1:0] r_addr;
  logic [BSEL_W-1:0] r_bsel;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_word;
  logic [DATA_W-1:0] r_rdata;

  logic [NUM_REQ-1:0] w_gnt;
  logic [IDX_W-1:0]   w_gnt_idx;
  logic               w_gnt_vld;
  logic               w_arb_en;
  logic [ADDR_W-1:0]  w_mem_addr;
  logic [DATA_W-1:0]  w_mem_wdata;
  logic               w_mem_rd;
  logic               w_mem_wr;
  logic [NUM_REQ-1:0] w_rsp_valid;

  // Holding grants off during reset keeps req_ready low while rst_n is asserted.
  assign w_arb_en = rst_n && (r_state == S_IDLE);

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_arb (
`ifndef MEM_ARB_FIXED_PRIO_EN
    .clk       (clk),
    .rst_n     (rst_n),
`endif
    .i_en      (w_arb_en),
    .i_req     (bus.req_valid),
    .o_gnt     (w_gnt),
    .o_gnt_idx (w_gnt_idx),
    .o_gnt_vld (w_gnt_vld)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_owner <= '0;
      r_write <= 1'b0;
      r_byte  <= 1'b0;
      r_addr  <= '0;
      r_bsel  <= '0;
      r_wdata <= '0;
      r_word  <= '0;
      r_rdata <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_gnt_vld) begin
            r_owner <= w_gnt_idx;
            r_write <= bus.req_write[w_gnt_idx];
            r_byte  <= bus.req_byte[w_gnt_idx];
            r_addr  <= bus.req_addr[w_gnt_idx*ADDR_W +: ADDR_W];
            r_bsel  <= bus.req_bsel[w_gnt_idx*BSEL_W +: BSEL_W];
            r_wdata <= bus.req_wdata[w_gnt_idx*DATA_W +: DATA_W];
            r_state <= (bus.req_write[w_gnt_idx] && bus.req_byte[w_gnt_idx])
                       ? S_RMW_RD : S_ACCESS;
          end
        end
        S_ACCESS: begin
          if (!r_write) begin
            r_rdata <= r_byte ? lane_extract(bus.mem_read_data, r_bsel)
                              : bus.mem_read_data;
          end else begin
            r_rdata <= '0;
          end
          r_state <= S_RESP;
        end
        S_RMW_RD: begin
          r_word  <= lane_merge(bus.mem_read_data, r_bsel, r_wdata[BYTE_W-1:0]);
          r_state <= S_RMW_WR;
        end
        S_RMW_WR: begin
          r_rdata <= '0;
          r_state <= S_RESP;
        end
        S_RESP: begin
          if (bus.rsp_ready[r_owner]) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    w_mem_addr  = '0;
    w_mem_wdata = '0;
    w_mem_rd    = 1'b0;
    w_mem_wr    = 1'b0;
    w_rsp_valid = '0;
    case (r_state)
      S_ACCESS: begin
        w_mem_addr  = r_addr;
        w_mem_rd    = !r_write;
        w_mem_wr    = r_write;
        w_mem_wdata = r_write ? r_wdata : '0;
      end
      S_RMW_RD: begin
        w_mem_addr = r_addr;
        w_mem_rd   = 1'b1;
      end
      S_RMW_WR: begin
        w_mem_addr  = r_addr;
        w_mem_wr    = 1'b1;
        w_mem_wdata = r_word;
      end
      S_RESP: w_rsp_valid[r_owner] = 1'b1;
      default: ;
    endcase
  end

  assign bus.req_ready      = w_gnt;
  assign bus.rsp_valid      = w_rsp_valid;
  assign bus.rsp_data       = (r_state == S_RESP) ? r_rdata : '0;
  assign bus.mem_address    = w_mem_addr;
  assign bus.mem_write_data = w_mem_wdata;
  assign bus.mem_read       = w_mem_rd;
  assign bus.mem_write      = w_mem_wr;
  assign bus.mem_byte_ops   = 1'b0;
  assign bus.busy           = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sequences and shares the single-ported 2^18 x 32 word memory between NUM_REQ requesters; default 2: port 0 = instruction fetch, port 1 = load/store unit.
- Accepts one request at a time over a valid/ready handshake, drives the memory's address/write_data/memRead/memWrite/byteOperations pins and returns read data on a response handshake.
- Byte stores run as read-modify-write; byte loads are zero-extended.

Parameters:
- NUM_REQ, 2, number of requesters (2..4).
- ADDR_W, 18, memory word-address width.
- DATA_W, 32, memory word width.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- req_valid  in  NUM_REQ  request present, per requester.
- req_ready  out  NUM_REQ  request accepted this cycle (one-hot or zero).
- req_write  in  NUM_REQ  1 = store, 0 = load.
- req_byte  in  NUM_REQ  1 = byte access, 0 = word access.
- req_addr  in  NUM_REQ*ADDR_W  word address, packed, requester i at [i*ADDR_W +: ADDR_W].
- req_bsel  in  NUM_REQ*2  byte lane; 0 = bits 7:0 … 3 = bits 31:24.
- req_wdata  in  NUM_REQ*DATA_W  store data; byte stores use bits 7:0.
- rsp_valid  out  NUM_REQ  response ready for requester i (one-hot or zero).
- rsp_ready  in  NUM_REQ  requester consumes response.
- rsp_data  out  DATA_W  load data (zero-extended for byte loads); 0 for stores.
- mem_address  out  ADDR_W  to memory address.
- mem_write_data  out  DATA_W  to memory write_data.
- mem_read  out  1  to memory memRead.
- mem_write  out  1  to memory memWrite.
- mem_byte_ops  out  1  to memory byteOperations; always 0, byte handling is done here.
- mem_read_data  in  DATA_W  from memory read_data; combinational, valid in the same cycle mem_read=1.
- busy  out  1  FSM not in IDLE.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - FSM to IDLE.
  - All outputs 0; rsp_data=0.
  - Round-robin pointer set to requester 0.
  - An in-flight operation is abandoned; a pending RMW write is never issued.
- States:
  - IDLE: pick requester, assert its req_ready for one cycle, latch its fields; go to ACCESS, or to RMW_RD for a byte store.
  - ACCESS: drive mem_address; for a load, mem_read=1 and capture mem_read_data, lane-select and zero-extend if byte; for a word store, mem_write=1 with mem_write_data=wdata. Then RESP.
  - RMW_RD: mem_read=1, capture word, merge wdata[7:0] into the bsel lane. Then RMW_WR.
  - RMW_WR: mem_write=1, mem_write_data=merged word. Then RESP.
  - RESP: rsp_valid[owner]=1 and rsp_data held stable until rsp_ready[owner]=1; then IDLE.
- Latency from accept cycle T: load or word store has rsp_valid at T+2; byte store at T+3. Max throughput is one request per 3 cycles (4 for byte stores).
- Memory pins are driven only in ACCESS, RMW_RD and RMW_WR. mem_read and mem_write are never both 1. mem_address and mem_write_data are 0 elsewhere.
- Arbitration (IDLE only): round-robin starting at the pointer. After a grant, the pointer moves to grant+1 mod NUM_REQ. With no valid request, nothing is granted and the pointer is unchanged.
- Request hold: a requester holds valid and its fields until ready. Deasserting valid before ready is allowed and withdraws the request.
- Response during RESP: a new req_valid from any port, including the owner, waits. It is not granted in the same cycle rsp_ready is seen; earliest grant is the next cycle.
- Address is never incremented internally; no wrap-around logic is needed.

Optional Feature:
- Macro MEM_ARB_FIXED_PRIO_EN.
- Defined: arbitration is fixed priority, lowest index wins (port 0 = fetch), and the pointer logic is removed.
- Undefined (default): round-robin as above.

Decomposition:
- Package mem_arb_pkg holds:
  - state enum (IDLE, ACCESS, RMW_RD, RMW_WR, RESP);
  - localparams BSEL_W=2 and BYTE_W=8;
  - function for lane extract;
  - function for lane merge.
- One natural sub-module, rr_arbiter: NUM_REQ-wide round-robin grant with pointer, plus the fixed-priority variant under the macro.

Test Plan:
- Word store port1, addr 0x00010, wdata 0xDEADBEEF, then word load port1 at the same address → memory write cycle seen at T+1; load rsp_data=0xDEADBEEF at T+2.
- Word 0x11223344 at addr 5, then byte store port1, bsel=2, wdata=0xAA → two memory cycles (read, write); memory word = 0x11AA3344; rsp_valid at T+3.
- Byte load addr 5, bsel=3 after the previous test → rsp_data=0x00000011.
- Both ports continuously valid, rsp_ready=1 → grants alternate 0,1,0,1. With MEM_ARB_FIXED_PRIO_EN defined → port 0 always wins.
- rsp_ready held 0 for 5 cycles in RESP → rsp_valid and rsp_data stable; no new grant; memory pins idle.
- rst_n=0 in RMW_RD → next cycle FSM is IDLE, no mem_write ever issued, memory word unchanged, all outputs 0.
